// File: rtl/somador_nbits_serial_if.sv
// Dual-rail operand/result bundle and 4-phase handshake for somador_nbits_serial.
// master = upstream/downstream environment, slave = the adder.
interface somador_nbits_serial_if #(
   parameter int unsigned N = 8
);
   logic [2*N-1:0] a;
   logic [2*N-1:0] b;
   logic [1:0]     cin;
   logic           ki;
   logic           ko;
   logic [2*N-1:0] soma;
   logic [1:0]     cout;
   logic           ocupado;
   logic           erro;

   modport master (
      output a, b, cin, ki,
      input  ko, soma, cout, ocupado, erro
   );

   modport slave (
      input  a, b, cin, ki,
      output ko, soma, cout, ocupado, erro
   );
endinterface

// File: rtl/somador_nbits_serial.sv
// Digit-serial dual-rail adder: (A + B + cin) mod 2^N, D bits per clock,
// wrapped in a 4-phase DATA/NULL handshake with registered outputs.
module somador_nbits_serial #(
   parameter int unsigned N = 8,
   parameter int unsigned D = 2
) (
   input logic                   clk,
   input logic                   rst,
   somador_nbits_serial_if.slave bus
);
   localparam int unsigned NDIG = N / D;
   localparam int unsigned CW   = (NDIG > 1) ? $clog2(NDIG) : 1;
   localparam logic [CW-1:0] ULT = CW'(NDIG - 1);

   typedef enum logic [1:0] {ESPERA, CALC, SAIDA, LIMPA} estado_t;

   estado_t        estado_q, estado_d;
   logic [N-1:0]   a_q, a_d, b_q, b_d, sum_q, sum_d;
   logic           carry_q, carry_d;
   logic [CW-1:0]  cnt_q, cnt_d;
   logic [2*N-1:0] soma_q, soma_d;
   logic [1:0]     cout_q, cout_d;
   logic           ko_q, ko_d, ocupado_q, ocupado_d, erro_q, erro_d;

   logic [N-1:0]   a_ok, b_ok, a_il, b_il, a_bits, b_bits;
   logic           dados_ok, nulo_ok, ilegal;
   logic [D:0]     parcial;
   logic [N-1:0]   sum_prox;
   logic [2*N-1:0] soma_enc;

   for (genvar i = 0; i < N; i++) begin : g_par
      assign a_ok[i]   = bus.a[2*i+1] ^ bus.a[2*i];
      assign b_ok[i]   = bus.b[2*i+1] ^ bus.b[2*i];
      assign a_il[i]   = bus.a[2*i+1] & bus.a[2*i];
      assign b_il[i]   = bus.b[2*i+1] & bus.b[2*i];
      assign a_bits[i] = bus.a[2*i+1];
      assign b_bits[i] = bus.b[2*i+1];
      assign soma_enc[2*i+1] = sum_prox[i];
      assign soma_enc[2*i]   = ~sum_prox[i];
   end

   assign dados_ok = (&a_ok) & (&b_ok) & (bus.cin[1] ^ bus.cin[0]);
   assign nulo_ok  = ~(|bus.a) & ~(|bus.b) & ~(|bus.cin);
   assign ilegal   = (|a_il) | (|b_il) | (&bus.cin);

   // Operands shift right one digit per cycle, so the active digit is always
   // the low D bits; result digits enter sum from the top and land in place
   // after NDIG cycles.
   assign parcial  = {1'b0, a_q[D-1:0]} + {1'b0, b_q[D-1:0]} + {{D{1'b0}}, carry_q};
   assign sum_prox = (sum_q >> D) | (N'(parcial[D-1:0]) << (N - D));

   always_comb begin
      estado_d = estado_q;
      a_d      = a_q;
      b_d      = b_q;
      sum_d    = sum_q;
      carry_d  = carry_q;
      cnt_d    = cnt_q;
      soma_d   = soma_q;
      cout_d   = cout_q;
      erro_d   = erro_q | ilegal;
      case (estado_q)
         ESPERA: begin
            if (dados_ok) begin
               a_d      = a_bits;
               b_d      = b_bits;
               carry_d  = bus.cin[1];
               sum_d    = '0;
               cnt_d    = '0;
               estado_d = CALC;
            end
         end
         CALC: begin
            a_d     = a_q >> D;
            b_d     = b_q >> D;
            carry_d = parcial[D];
            sum_d   = sum_prox;
            cnt_d   = cnt_q + CW'(1);
            if (cnt_q == ULT) begin
               cnt_d    = '0;
               soma_d   = soma_enc;
               cout_d   = {parcial[D], ~parcial[D]};
               estado_d = SAIDA;
            end
         end
         SAIDA: begin
            if (!bus.ki) begin
               soma_d   = '0;
               cout_d   = '0;
               estado_d = LIMPA;
            end
         end
         LIMPA: begin
            if (nulo_ok && bus.ki) estado_d = ESPERA;
         end
         default: estado_d = ESPERA;
      endcase
      ko_d      = (estado_d == ESPERA);
      ocupado_d = (estado_d != ESPERA);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         estado_q  <= ESPERA;
         a_q       <= '0;
         b_q       <= '0;
         sum_q     <= '0;
         carry_q   <= 1'b0;
         cnt_q     <= '0;
         soma_q    <= '0;
         cout_q    <= '0;
         ko_q      <= 1'b1;
         ocupado_q <= 1'b0;
         erro_q    <= 1'b0;
      end else begin
         estado_q  <= estado_d;
         a_q       <= a_d;
         b_q       <= b_d;
         sum_q     <= sum_d;
         carry_q   <= carry_d;
         cnt_q     <= cnt_d;
         soma_q    <= soma_d;
         cout_q    <= cout_d;
         ko_q      <= ko_d;
         ocupado_q <= ocupado_d;
         erro_q    <= erro_d;
      end
   end

   assign bus.ko      = ko_q;
   assign bus.soma    = soma_q;
   assign bus.cout    = cout_q;
   assign bus.ocupado = ocupado_q;
   assign bus.erro    = erro_q;
endmodule

// File: tb/tb_somador_nbits_serial.sv
// Bench for somador_nbits_serial: three N=8 instances (D=1, 2, 8) share the
// same stimulus and are compared against a plain-arithmetic sum model.
module tb_somador_nbits_serial;
   localparam int unsigned N = 8;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic [2*N-1:0] a_drv, b_drv;
   logic [1:0]     cin_drv;
   logic           ki_drv;

   somador_nbits_serial_if #(.N(N)) if_d1 ();
   somador_nbits_serial_if #(.N(N)) if_d2 ();
   somador_nbits_serial_if #(.N(N)) if_d8 ();

   assign if_d1.a = a_drv;  assign if_d1.b = b_drv;  assign if_d1.cin = cin_drv;  assign if_d1.ki = ki_drv;
   assign if_d2.a = a_drv;  assign if_d2.b = b_drv;  assign if_d2.cin = cin_drv;  assign if_d2.ki = ki_drv;
   assign if_d8.a = a_drv;  assign if_d8.b = b_drv;  assign if_d8.cin = cin_drv;  assign if_d8.ki = ki_drv;

   somador_nbits_serial #(.N(N), .D(1)) dut_d1 (.clk(clk), .rst(rst), .bus(if_d1));
   somador_nbits_serial #(.N(N), .D(2)) dut_d2 (.clk(clk), .rst(rst), .bus(if_d2));
   somador_nbits_serial #(.N(N), .D(8)) dut_d8 (.clk(clk), .rst(rst), .bus(if_d8));

   logic [2*N-1:0] soma_w [3];
   logic [1:0]     cout_w [3];
   logic           ko_w [3], ocup_w [3], erro_w [3];
   int             lat_exp [3];

   assign soma_w[0] = if_d1.soma;  assign cout_w[0] = if_d1.cout;  assign ko_w[0] = if_d1.ko;
   assign soma_w[1] = if_d2.soma;  assign cout_w[1] = if_d2.cout;  assign ko_w[1] = if_d2.ko;
   assign soma_w[2] = if_d8.soma;  assign cout_w[2] = if_d8.cout;  assign ko_w[2] = if_d8.ko;
   assign ocup_w[0] = if_d1.ocupado;  assign erro_w[0] = if_d1.erro;
   assign ocup_w[1] = if_d2.ocupado;  assign erro_w[1] = if_d2.erro;
   assign ocup_w[2] = if_d8.ocupado;  assign erro_w[2] = if_d8.erro;

   int n_checks = 0;
   int n_errors = 0;

   task automatic verifica(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [2*N-1:0] enc(input logic [N-1:0] v);
      logic [2*N-1:0] r;
      for (int i = 0; i < int'(N); i++) begin
         r[2*i+1] = v[i];
         r[2*i]   = ~v[i];
      end
      return r;
   endfunction

   function automatic logic [1:0] enc1(input logic v);
      return {v, ~v};
   endfunction

   function automatic bit is_data(input logic [2*N-1:0] s);
      bit ok = 1'b1;
      for (int i = 0; i < int'(N); i++) ok &= (s[2*i+1] ^ s[2*i]);
      return ok;
   endfunction

   function automatic logic [N:0] modelo(input logic [N-1:0] av, input logic [N-1:0] bv, input logic cv);
      int unsigned t = int'(av) + int'(bv) + int'(cv);
      return t[N:0];
   endfunction

   task automatic drive_data(input logic [N-1:0] av, input logic [N-1:0] bv, input logic cv);
      @(negedge clk);
      a_drv   = enc(av);
      b_drv   = enc(bv);
      cin_drv = enc1(cv);
      ki_drv  = 1'b1;
   endtask

   task automatic run_op(input logic [N-1:0] av, input logic [N-1:0] bv, input logic cv,
                         input int stall, input bit junk, input int modo);
      logic [N:0] exp;
      int         lat [3];
      int         cyc;
      bit         done;
      exp = modelo(av, bv, cv);
      drive_data(av, bv, cv);
      lat  = '{-1, -1, -1};
      cyc  = 0;
      done = 1'b0;
      while (!done && cyc < 20) begin
         @(posedge clk); #1;
         cyc++;
         if (cyc == 1) begin
            for (int k = 0; k < 3; k++) begin
               verifica($sformatf("ko_after_capture_%0d", k), 32'(ko_w[k]), 32'd0);
               verifica($sformatf("ocupado_after_capture_%0d", k), 32'(ocup_w[k]), 32'd1);
            end
         end
         if (junk) begin
            a_drv   = enc(N'($urandom));
            b_drv   = enc(N'($urandom));
            cin_drv = enc1(1'($urandom));
         end
         done = 1'b1;
         for (int k = 0; k < 3; k++) begin
            if (lat[k] < 0 && is_data(soma_w[k])) lat[k] = cyc - 1;
            if (lat[k] < 0) done = 1'b0;
         end
      end
      for (int k = 0; k < 3; k++) begin
         verifica($sformatf("latency_%0d", k), 32'(lat[k]), 32'(lat_exp[k]));
         verifica($sformatf("soma_%0d", k), 32'(soma_w[k]), 32'(enc(exp[N-1:0])));
         verifica($sformatf("cout_%0d", k), 32'(cout_w[k]), 32'(enc1(exp[N])));
      end
      repeat (stall) begin
         @(posedge clk); #1;
         for (int k = 0; k < 3; k++)
            verifica($sformatf("soma_stall_%0d", k), 32'(soma_w[k]), 32'(enc(exp[N-1:0])));
      end
      ki_drv = 1'b0;
      @(posedge clk); #1;
      for (int k = 0; k < 3; k++) begin
         verifica($sformatf("soma_null_%0d", k), 32'(soma_w[k]), 32'd0);
         verifica($sformatf("cout_null_%0d", k), 32'(cout_w[k]), 32'd0);
         verifica($sformatf("ko_limpa_%0d", k), 32'(ko_w[k]), 32'd0);
      end
      // Three orderings of the return-to-NULL half of the handshake.
      if (modo == 0) begin
         a_drv = '0; b_drv = '0; cin_drv = '0;
         @(posedge clk); #1;
         verifica("ko_wait_ki", 32'(ko_w[1]), 32'd0);
         ki_drv = 1'b1;
      end else if (modo == 1) begin
         ki_drv = 1'b1;
         @(posedge clk); #1;
         verifica("ko_wait_null", 32'(ko_w[1]), 32'd0);
         a_drv = '0; b_drv = '0; cin_drv = '0;
      end else begin
         a_drv = '0; b_drv = '0; cin_drv = '0;
         ki_drv = 1'b1;
      end
      @(posedge clk); #1;
      for (int k = 0; k < 3; k++) begin
         verifica($sformatf("ko_espera_%0d", k), 32'(ko_w[k]), 32'd1);
         verifica($sformatf("ocupado_espera_%0d", k), 32'(ocup_w[k]), 32'd0);
      end
   endtask

   initial begin
      lat_exp = '{8, 4, 1};
      rst     = 1'b1;
      a_drv   = '0;
      b_drv   = '0;
      cin_drv = '0;
      ki_drv  = 1'b1;
      repeat (2) @(negedge clk);
      for (int k = 0; k < 3; k++) begin
         verifica($sformatf("rst_ko_%0d", k), 32'(ko_w[k]), 32'd1);
         verifica($sformatf("rst_soma_%0d", k), 32'(soma_w[k]), 32'd0);
         verifica($sformatf("rst_cout_%0d", k), 32'(cout_w[k]), 32'd0);
         verifica($sformatf("rst_ocupado_%0d", k), 32'(ocup_w[k]), 32'd0);
         verifica($sformatf("rst_erro_%0d", k), 32'(erro_w[k]), 32'd0);
      end
      rst = 1'b0;

      run_op(8'h5A, 8'h3C, 1'b0, 0, 1'b0, 2);
      run_op(8'hFF, 8'h01, 1'b1, 0, 1'b0, 0);
      run_op(8'h00, 8'h00, 1'b0, 0, 1'b0, 1);
      run_op(8'hFF, 8'hFF, 1'b1, 10, 1'b1, 0);

      // Partial wavefront: a, then b, then cin.
      @(negedge clk);
      a_drv = enc(8'h33);
      repeat (2) begin
         @(posedge clk); #1;
         verifica("partial_a_ko", 32'(ko_w[1]), 32'd1);
         verifica("partial_a_ocupado", 32'(ocup_w[0]), 32'd0);
      end
      b_drv = enc(8'hC4);
      repeat (2) begin
         @(posedge clk); #1;
         verifica("partial_ab_ko", 32'(ko_w[2]), 32'd1);
      end
      run_op(8'h33, 8'hC4, 1'b1, 1, 1'b0, 2);

      // Illegal pair blocks capture and latches erro until reset.
      @(negedge clk);
      a_drv   = enc(8'h12);
      b_drv   = enc(8'h34);
      b_drv[5:4] = 2'b11;
      cin_drv = enc1(1'b0);
      repeat (2) begin
         @(posedge clk); #1;
         for (int k = 0; k < 3; k++) begin
            verifica($sformatf("illegal_erro_%0d", k), 32'(erro_w[k]), 32'd1);
            verifica($sformatf("illegal_ko_%0d", k), 32'(ko_w[k]), 32'd1);
         end
      end
      run_op(8'h12, 8'h34, 1'b0, 0, 1'b0, 0);
      for (int k = 0; k < 3; k++)
         verifica($sformatf("erro_sticky_%0d", k), 32'(erro_w[k]), 32'd1);

      // Reset pulse in the middle of CALC.
      drive_data(8'h77, 8'h11, 1'b0);
      repeat (2) @(posedge clk);
      #3 rst = 1'b1;
      #1;
      for (int k = 0; k < 3; k++) begin
         verifica($sformatf("midrst_ko_%0d", k), 32'(ko_w[k]), 32'd1);
         verifica($sformatf("midrst_soma_%0d", k), 32'(soma_w[k]), 32'd0);
         verifica($sformatf("midrst_cout_%0d", k), 32'(cout_w[k]), 32'd0);
         verifica($sformatf("midrst_ocupado_%0d", k), 32'(ocup_w[k]), 32'd0);
         verifica($sformatf("midrst_erro_%0d", k), 32'(erro_w[k]), 32'd0);
      end
      a_drv = '0; b_drv = '0; cin_drv = '0;
      @(negedge clk);
      rst = 1'b0;
      run_op(8'h10, 8'h20, 1'b0, 0, 1'b0, 2);

      for (int t = 0; t < 20; t++)
         run_op(8'($urandom), 8'($urandom), 1'($urandom), int'($urandom_range(0, 3)),
                1'($urandom), int'($urandom_range(0, 2)));

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end
endmodule
